// File: rtl/pipe_stage_reg.sv
// Generic handshaked pipeline stage register with flush and bubble masking of the control field.
// Define PIPE_STAGE_SKID_EN to add a skid entry, which registers in_ready_o while keeping full throughput.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W   = 160,
  parameter int unsigned       CTRL_W   = 8,
  parameter logic [CTRL_W-1:0] CTRL_RST = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic              main_free;
  logic              up_xfer;

  assign main_free = !main_valid || out_ready_i;
  assign up_xfer   = in_valid_i && in_ready_o;

`ifdef PIPE_STAGE_SKID_EN
  logic              skid_valid;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  // Ready depends only on held state, so there is no path from out_ready_i.
  assign in_ready_o = !skid_valid && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      skid_ctrl  <= '0;
    end else if (main_free) begin
      if (skid_valid) begin
        main_valid <= 1'b1;
        main_data  <= skid_data;
        main_ctrl  <= skid_ctrl;
        skid_valid <= 1'b0;
      end else if (up_xfer) begin
        main_valid <= 1'b1;
        main_data  <= in_data_i;
        main_ctrl  <= in_ctrl_i;
      end else begin
        main_valid <= 1'b0;
      end
    end else if (up_xfer) begin
      skid_valid <= 1'b1;
      skid_data  <= in_data_i;
      skid_ctrl  <= in_ctrl_i;
    end
  end
`else
  assign in_ready_o = main_free && !rst;

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= '0;
    end else if (main_free) begin
      if (up_xfer) begin
        main_valid <= 1'b1;
        main_data  <= in_data_i;
        main_ctrl  <= in_ctrl_i;
      end else begin
        main_valid <= 1'b0;
      end
    end
  end
`endif

  // A bubble must never present a side-effecting control word downstream.
  assign out_valid_o = main_valid;
  assign out_data_o  = main_data;
  assign out_ctrl_o  = main_valid ? main_ctrl : CTRL_RST;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and model-checked bench for pipe_stage_reg, usable with or without PIPE_STAGE_SKID_EN.
module tb_pipe_stage_reg;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CRST = 8'h3C;

  logic          clk;
  logic          rst;
  logic          flush_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i;
  logic [CW-1:0] in_ctrl_i;
  logic          out_valid_o;
  logic          out_ready_i;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] out_ctrl_o;

  int n_cmp = 0;
  int n_err = 0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CTRL_RST(CRST)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_data_i(in_data_i), .in_ctrl_i(in_ctrl_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_ctrl_o(out_ctrl_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c);
    in_valid_i = v;
    in_data_i  = d;
    in_ctrl_i  = c;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b1;
    send(1'b1, 16'hA5A5, 8'hFF);
    tick(); tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    n_cmp++; if (out_ctrl_o !== CRST) begin n_err++; $display("FAIL reset_ctrl: got %h expected %h", out_ctrl_o, CRST); end
    n_cmp++; if (out_data_o !== 16'h0000) begin n_err++; $display("FAIL reset_data: got %h expected 0000", out_data_o); end
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b expected 0", in_ready_o); end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b expected 1", in_ready_o); end
    tick();
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 16'hA5A5) begin
      n_err++; $display("FAIL first_accept: got valid=%b data=%h expected valid=1 data=a5a5", out_valid_o, out_data_o);
    end
    send(1'b0, 16'h0, 8'h0);
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_drain: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_streaming();
    out_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      send(1'b1, DW'(i), CW'(i));
      #1;
      n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL stream_ready[%0d]: got %b expected 1", i, in_ready_o); end
      tick();
      n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== DW'(i) || out_ctrl_o !== CW'(i)) begin
        n_err++; $display("FAIL stream_out[%0d]: got v=%b d=%h c=%h expected v=1 d=%h c=%h", i, out_valid_o, out_data_o, out_ctrl_o, DW'(i), CW'(i));
      end
    end
    send(1'b0, 16'h0, 8'h0);
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL stream_end: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_backpressure();
    out_ready_i = 1'b0;
    send(1'b1, 16'd1, 8'h01);
    tick();
    n_cmp++; if (out_data_o !== 16'd1 || out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_first: got v=%b d=%h expected v=1 d=0001", out_valid_o, out_data_o); end
    send(1'b1, 16'd2, 8'h02);
`ifdef PIPE_STAGE_SKID_EN
    tick();
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_skid_full: got %b expected 0", in_ready_o); end
    send(1'b1, 16'd3, 8'h03);
    tick();
    n_cmp++; if (out_data_o !== 16'd1 || in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_hold: got d=%h rdy=%b expected d=0001 rdy=0", out_data_o, in_ready_o); end
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_registered_ready: got %b expected 0", in_ready_o); end
    tick();
    n_cmp++; if (out_data_o !== 16'd2 || in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_drain: got d=%h rdy=%b expected d=0002 rdy=1", out_data_o, in_ready_o); end
    tick();
    n_cmp++; if (out_data_o !== 16'd3 || out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_third: got v=%b d=%h expected v=1 d=0003", out_valid_o, out_data_o); end
`else
    #1;
    n_cmp++; if (in_ready_o !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready: got %b expected 0", in_ready_o); end
    tick();
    n_cmp++; if (out_data_o !== 16'd1) begin n_err++; $display("FAIL bp_hold: got %h expected 0001", out_data_o); end
    out_ready_i = 1'b1;
    #1;
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL bp_comb_ready: got %b expected 1", in_ready_o); end
    tick();
    n_cmp++; if (out_data_o !== 16'd2) begin n_err++; $display("FAIL bp_second: got %h expected 0002", out_data_o); end
    send(1'b1, 16'd3, 8'h03);
    tick();
    n_cmp++; if (out_data_o !== 16'd3 || out_valid_o !== 1'b1) begin n_err++; $display("FAIL bp_third: got v=%b d=%h expected v=1 d=0003", out_valid_o, out_data_o); end
`endif
    send(1'b0, 16'h0, 8'h0);
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL bp_empty: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_flush();
    out_ready_i = 1'b0;
    send(1'b1, 16'd10, 8'h10);
    tick();
    send(1'b1, 16'd11, 8'h11);
    tick();
    flush_i = 1'b1;
    send(1'b1, 16'd9, 8'h09);
    tick();
    flush_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0 || out_ctrl_o !== CRST || out_data_o !== 16'h0) begin
      n_err++; $display("FAIL flush_clear: got v=%b c=%h d=%h expected v=0 c=%h d=0000", out_valid_o, out_ctrl_o, out_data_o, CRST);
    end
    n_cmp++; if (in_ready_o !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b expected 1", in_ready_o); end
    send(1'b0, 16'h0, 8'h0);
    out_ready_i = 1'b1;
    tick();
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_no_ghost: got v=%b d=%h expected v=0", out_valid_o, out_data_o); end
    // flush coinciding with a downstream transfer
    send(1'b1, 16'd12, 8'h12);
    tick();
    send(1'b0, 16'h0, 8'h0);
    flush_i = 1'b1;
    #1;
    n_cmp++; if (out_valid_o !== 1'b1 || out_data_o !== 16'd12) begin n_err++; $display("FAIL flush_xfer_seen: got v=%b d=%h expected v=1 d=000c", out_valid_o, out_data_o); end
    tick();
    flush_i = 1'b0;
    n_cmp++; if (out_valid_o !== 1'b0) begin n_err++; $display("FAIL flush_xfer_clear: got %b expected 0", out_valid_o); end
  endtask

  task automatic test_bubble();
    out_ready_i = 1'b1;
    send(1'b1, 16'h0077, 8'hFF);
    tick();
    n_cmp++; if (out_ctrl_o !== 8'hFF) begin n_err++; $display("FAIL bubble_live_ctrl: got %h expected ff", out_ctrl_o); end
    send(1'b0, 16'h0, 8'hFF);
    tick();
    n_cmp++; if (out_valid_o !== 1'b0 || out_ctrl_o !== CRST) begin
      n_err++; $display("FAIL bubble_mask: got v=%b c=%h expected v=0 c=%h", out_valid_o, out_ctrl_o, CRST);
    end
  endtask

  task automatic test_random();
    logic [CW+DW-1:0] q[$];
    logic             exp_ready;
    int               errs_before;
    errs_before = n_err;
    flush_i = 1'b1; send(1'b0, 16'h0, 8'h0);
    tick();
    flush_i = 1'b0;
    for (int i = 0; i < 3000 && (n_err - errs_before) < 20; i++) begin
      send($urandom_range(0, 3) != 0, DW'($urandom), CW'($urandom));
      out_ready_i = $urandom_range(0, 2) != 0;
      flush_i     = $urandom_range(0, 31) == 0;
      #1;
`ifdef PIPE_STAGE_SKID_EN
      exp_ready = q.size() < 2;
`else
      exp_ready = (q.size() == 0) || out_ready_i;
`endif
      n_cmp++; if (in_ready_o !== exp_ready) begin n_err++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, in_ready_o, exp_ready); end
      n_cmp++; if (out_valid_o !== (q.size() != 0)) begin n_err++; $display("FAIL rand_valid[%0d]: got %b expected %b", i, out_valid_o, q.size() != 0); end
      if (q.size() != 0) begin
        n_cmp++; if ({out_ctrl_o, out_data_o} !== q[0]) begin
          n_err++; $display("FAIL rand_entry[%0d]: got %h expected %h", i, {out_ctrl_o, out_data_o}, q[0]);
        end
      end else begin
        n_cmp++; if (out_ctrl_o !== CRST) begin n_err++; $display("FAIL rand_mask[%0d]: got %h expected %h", i, out_ctrl_o, CRST); end
      end
      if (q.size() != 0 && out_ready_i) void'(q.pop_front());
      if (flush_i) q.delete();
      else if (in_valid_i && exp_ready) q.push_back({in_ctrl_i, in_data_i});
      tick();
    end
    flush_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0;
    send(1'b0, 16'h0, 8'h0);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
